// File: rtl/ber_gpio_regfile_pkg.sv
// Shared definitions for the GPIO register file: command field positions,
// opcodes, fixed read-back words and the command FSM state encoding.
package ber_gpio_regfile_pkg;

  localparam int STRB_BIT = 23;
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 24;

  localparam logic [7:0] OP_SET_CTRL = 8'h01;
  localparam logic [7:0] OP_SNAPSHOT = 8'h02;
  localparam logic [7:0] OP_READ     = 8'h03;
  localparam logic [7:0] OP_STATUS   = 8'h04;

  localparam logic [31:0] DATA_SNAP_DONE = 32'h0000_0001;
  localparam logic [31:0] DATA_BAD_OP    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/ber_gpio_regfile_rst_pulse_gen.sv
// Loadable down-counter that holds the datapath soft reset low for
// RST_CYCLES clocks after each load; a load while counting restarts it.
module rst_pulse_gen #(
  parameter int RST_CYCLES = 16
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_load,
  output logic o_tx_reset_n,
  output logic o_busy
);

  localparam int CNT_W = $clog2(RST_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload has priority, otherwise count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = CNT_W'(RST_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register, cleared by the hard reset so the datapath runs.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_busy       = (cnt_q != '0);
  assign o_tx_reset_n = ~o_busy;

endmodule

// File: rtl/ber_gpio_regfile.sv
// GPIO command bridge for the TX/BER datapath: decodes strobed commands,
// drives switches and soft reset, and reads back an atomic snapshot of the
// four 64-bit BER counters one 32-bit word at a time.
module ber_gpio_regfile #(
  parameter int NB_GPIO    = 32,
  parameter int NB_CNT     = 64,
  parameter int RST_CYCLES = 16
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_GPIO-1:0] i_gpio_cmd,
  output logic [NB_GPIO-1:0] o_gpio_data,
  output logic               o_ack,
  input  logic [NB_CNT-1:0]  i_err_i,
  input  logic [NB_CNT-1:0]  i_err_q,
  input  logic [NB_CNT-1:0]  i_bits_i,
  input  logic [NB_CNT-1:0]  i_bits_q,
  input  logic [3:0]         i_led,
  output logic [3:0]         o_sw,
  output logic               o_tx_reset_n
);

  import ber_gpio_regfile_pkg::*;

  state_t             state_q, state_d;
  logic               strb_q, strb_d;
  logic [7:0]         opc_q, opc_d;
  logic [4:0]         pay_q, pay_d;
  logic [NB_GPIO-1:0] data_q, data_d;
  logic               ack_q, ack_d;
  logic [3:0]         sw_q, sw_d;
  logic [NB_CNT-1:0]  snap_err_i_q, snap_err_i_d;
  logic [NB_CNT-1:0]  snap_err_q_q, snap_err_q_d;
  logic [NB_CNT-1:0]  snap_bits_i_q, snap_bits_i_d;
  logic [NB_CNT-1:0]  snap_bits_q_q, snap_bits_q_d;

  logic               strobe;
  logic               rise;
  logic               rst_load;
  logic               rst_busy;
  logic [NB_GPIO-1:0] read_word;
  logic               unused_cmd;

  // Only payload[4:0] carries meaning for any opcode; the rest is don't-care.
  assign unused_cmd = ^i_gpio_cmd[STRB_BIT-1:5];

  assign strobe = i_gpio_cmd[STRB_BIT];
  assign rise   = strobe & ~strb_q;

  rst_pulse_gen #(
    .RST_CYCLES (RST_CYCLES)
  ) u_rst_pulse (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_load       (rst_load),
    .o_tx_reset_n (o_tx_reset_n),
    .o_busy       (rst_busy)
  );

  // Word select into the held snapshot; the live counters are never read here.
  always_comb begin
    read_word = '0;
    case (pay_q[2:0])
      3'd0:    read_word = snap_err_i_q[NB_GPIO-1:0];
      3'd1:    read_word = snap_err_i_q[2*NB_GPIO-1:NB_GPIO];
      3'd2:    read_word = snap_err_q_q[NB_GPIO-1:0];
      3'd3:    read_word = snap_err_q_q[2*NB_GPIO-1:NB_GPIO];
      3'd4:    read_word = snap_bits_i_q[NB_GPIO-1:0];
      3'd5:    read_word = snap_bits_i_q[2*NB_GPIO-1:NB_GPIO];
      3'd6:    read_word = snap_bits_q_q[NB_GPIO-1:0];
      default: read_word = snap_bits_q_q[2*NB_GPIO-1:NB_GPIO];
    endcase
  end

  // Command FSM: accept a strobe rise in IDLE, execute for one cycle, then
  // hold the acknowledge until the host drops the strobe.
  always_comb begin
    state_d       = state_q;
    strb_d        = strobe;
    opc_d         = opc_q;
    pay_d         = pay_q;
    data_d        = data_q;
    ack_d         = ack_q;
    sw_d          = sw_q;
    snap_err_i_d  = snap_err_i_q;
    snap_err_q_d  = snap_err_q_q;
    snap_bits_i_d = snap_bits_i_q;
    snap_bits_q_d = snap_bits_q_q;
    rst_load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          opc_d   = i_gpio_cmd[OPC_MSB:OPC_LSB];
          pay_d   = i_gpio_cmd[4:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_ACK;
        ack_d   = 1'b1;
        case (opc_q)
          OP_SET_CTRL: begin
            sw_d     = pay_q[3:0];
            rst_load = pay_q[4];
            data_d   = NB_GPIO'(pay_q[3:0]);
          end
          OP_SNAPSHOT: begin
            snap_err_i_d  = i_err_i;
            snap_err_q_d  = i_err_q;
            snap_bits_i_d = i_bits_i;
            snap_bits_q_d = i_bits_q;
            data_d        = DATA_SNAP_DONE;
          end
          OP_READ:   data_d = read_word;
          OP_STATUS: data_d = NB_GPIO'({rst_busy, i_led, sw_q});
          default:   data_d = DATA_BAD_OP;
        endcase
      end
      ST_ACK: begin
        if (!strobe) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  // State, command latch, outputs and snapshot; all cleared by hard reset.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= ST_IDLE;
      strb_q        <= 1'b0;
      opc_q         <= '0;
      pay_q         <= '0;
      data_q        <= '0;
      ack_q         <= 1'b0;
      sw_q          <= '0;
      snap_err_i_q  <= '0;
      snap_err_q_q  <= '0;
      snap_bits_i_q <= '0;
      snap_bits_q_q <= '0;
    end else begin
      state_q       <= state_d;
      strb_q        <= strb_d;
      opc_q         <= opc_d;
      pay_q         <= pay_d;
      data_q        <= data_d;
      ack_q         <= ack_d;
      sw_q          <= sw_d;
      snap_err_i_q  <= snap_err_i_d;
      snap_err_q_q  <= snap_err_q_d;
      snap_bits_i_q <= snap_bits_i_d;
      snap_bits_q_q <= snap_bits_q_d;
    end
  end

  assign o_gpio_data = data_q;
  assign o_ack       = ack_q;
  assign o_sw        = sw_q;

endmodule

// File: tb/tb_ber_gpio_regfile.sv
// Self-checking bench for ber_gpio_regfile: directed scenarios plus random
// commands, compared against a command-level model of the register file.
module tb_ber_gpio_regfile;

  logic        clock;
  logic        i_reset;
  logic [31:0] i_gpio_cmd;
  logic [31:0] o_gpio_data;
  logic        o_ack;
  logic [63:0] i_err_i, i_err_q, i_bits_i, i_bits_q;
  logic [3:0]  i_led;
  logic [3:0]  o_sw;
  logic        o_tx_reset_n;

  int checks   = 0;
  int failures = 0;

  // Model state: switches, snapshot words, last read-back, soft-reset clocks left.
  logic [3:0]  m_sw;
  logic [63:0] m_snap [4];
  logic [31:0] m_data;
  int          rst_left;
  int          low_cycles;

  ber_gpio_regfile #(
    .NB_GPIO    (32),
    .NB_CNT     (64),
    .RST_CYCLES (16)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_gpio_cmd   (i_gpio_cmd),
    .o_gpio_data  (o_gpio_data),
    .o_ack        (o_ack),
    .i_err_i      (i_err_i),
    .i_err_q      (i_err_q),
    .i_bits_i     (i_bits_i),
    .i_bits_q     (i_bits_q),
    .i_led        (i_led),
    .o_sw         (o_sw),
    .o_tx_reset_n (o_tx_reset_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rst_left > 0) rst_left--;
    if (!o_tx_reset_n) low_cycles++;
  endtask

  task automatic model_hard_reset();
    m_sw     = 4'h0;
    m_data   = 32'h0;
    rst_left = 0;
    for (int k = 0; k < 4; k++) m_snap[k] = 64'h0;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      check({tag, "_txrst"}, 64'(o_tx_reset_n), 64'(rst_left == 0));
    end
  endtask

  task automatic randomize_inputs();
    i_err_i  = {$urandom, $urandom};
    i_err_q  = {$urandom, $urandom};
    i_bits_i = {$urandom, $urandom};
    i_bits_q = {$urandom, $urandom};
    i_led    = 4'($urandom);
  endtask

  // Full host transaction: raise strobe, expect the result with o_ack two
  // clocks later, hold the strobe 'hold' extra clocks, then drop it.
  task automatic send_cmd(input logic [7:0] op, input logic [22:0] p, input int hold,
                          input string tag);
    logic        busy;
    logic [31:0] exp;
    logic [63:0] w;
    int          idx;
    i_gpio_cmd = {op, 1'b1, p};
    tick();
    check({tag, "_ack_early"}, 64'(o_ack), 64'd0);
    busy = (rst_left != 0);
    case (op)
      8'h01: begin
        m_sw = p[3:0];
        exp  = {28'd0, p[3:0]};
      end
      8'h02: begin
        m_snap[0] = i_err_i;
        m_snap[1] = i_err_q;
        m_snap[2] = i_bits_i;
        m_snap[3] = i_bits_q;
        exp = 32'h0000_0001;
      end
      8'h03: begin
        idx = int'(p[2:0]);
        w   = m_snap[idx / 2];
        exp = (idx % 2 == 1) ? w[63:32] : w[31:0];
      end
      8'h04:   exp = {23'd0, busy, i_led, m_sw};
      default: exp = 32'hFFFF_FFFF;
    endcase
    tick();
    if (op == 8'h01 && p[4]) rst_left = 16;
    m_data = exp;
    check({tag, "_ack"},   64'(o_ack), 64'd1);
    check({tag, "_data"},  64'(o_gpio_data), 64'(m_data));
    check({tag, "_sw"},    64'(o_sw), 64'(m_sw));
    check({tag, "_txrst"}, 64'(o_tx_reset_n), 64'(rst_left == 0));
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold_ack"}, 64'(o_ack), 64'd1);
    end
    i_gpio_cmd[23] = 1'b0;
    tick();
    check({tag, "_ack_drop"},  64'(o_ack), 64'd0);
    check({tag, "_data_keep"}, 64'(o_gpio_data), 64'(m_data));
  endtask

  initial begin
    logic [7:0]  op;
    logic [22:0] pl;
    int          sel;

    i_reset    = 1'b1;
    i_gpio_cmd = 32'h0;
    i_err_i    = 64'h0;
    i_err_q    = 64'h0;
    i_bits_i   = 64'h0;
    i_bits_q   = 64'h0;
    i_led      = 4'h0;
    low_cycles = 0;
    model_hard_reset();

    // Hard reset with an idle command word.
    #1 i_reset = 1'b0;
    #2;
    check("rst_sw",    64'(o_sw), 64'h0);
    check("rst_ack",   64'(o_ack), 64'h0);
    check("rst_txrst", 64'(o_tx_reset_n), 64'h1);
    check("rst_data",  64'(o_gpio_data), 64'h0);
    @(posedge clock);
    #1 i_reset = 1'b1;
    idle_cycles(2, "post_rst");

    // SET_CTRL with soft-reset pulse: switches 0xD, reset low exactly 16 clocks.
    low_cycles = 0;
    send_cmd(8'h01, 23'h00001D, 0, "setctrl");
    check("setctrl_sw_lit", 64'(o_sw), 64'hD);
    idle_cycles(20, "pulse");
    check("pulse_len", 64'(low_cycles), 64'd16);

    // Snapshot then change the live counter: reads return snapshot values.
    randomize_inputs();
    i_err_i = 64'h0000_0005_0000_0007;
    send_cmd(8'h02, 23'h0, 0, "snap");
    i_err_i = {$urandom, $urandom};
    send_cmd(8'h03, {20'($urandom), 3'd0}, 0, "read0");
    check("read0_lit", 64'(o_gpio_data), 64'h7);
    send_cmd(8'h03, {20'($urandom), 3'd1}, 0, "read1");
    check("read1_lit", 64'(o_gpio_data), 64'h5);
    for (int k = 2; k < 8; k++) send_cmd(8'h03, {20'($urandom), 3'(k)}, 0, "readn");

    // New opcode with the strobe still high in ACK must not execute.
    i_gpio_cmd = {8'h03, 1'b1, 23'h000006};
    tick();
    tick();
    m_data = m_snap[3][31:0];
    check("ackhold_first", 64'(o_gpio_data), 64'(m_data));
    i_gpio_cmd = {8'h7F, 1'b1, 23'h000000};
    idle_cycles(3, "ackhold");
    check("ackhold_ack",  64'(o_ack), 64'd1);
    check("ackhold_data", 64'(o_gpio_data), 64'(m_data));
    i_gpio_cmd[23] = 1'b0;
    tick();
    check("ackhold_drop", 64'(o_ack), 64'd0);

    // Unknown opcode and STATUS read-back.
    send_cmd(8'h7F, 23'($urandom), 0, "badop");
    check("badop_lit", 64'(o_gpio_data), 64'hFFFF_FFFF);
    send_cmd(8'h01, 23'h000003, 0, "sw3");
    i_led = 4'hA;
    send_cmd(8'h04, 23'h0, 0, "status");
    check("status_lit", 64'(o_gpio_data), 64'hA3);

    // Commands during the soft reset, including a retrigger and a snapshot.
    send_cmd(8'h01, 23'h000016, 0, "pulse2");
    idle_cycles(4, "pulse2");
    send_cmd(8'h04, 23'h0, 1, "status_busy");
    send_cmd(8'h01, 23'h000019, 0, "retrig");
    randomize_inputs();
    send_cmd(8'h02, 23'h0, 0, "snap_busy");
    send_cmd(8'h03, 23'h000005, 0, "read_busy");
    idle_cycles(18, "retrig");

    // Hard reset in ACK while the pulse runs; strobe stays high across it.
    i_gpio_cmd = {8'h01, 1'b1, 23'h000015};
    tick();
    tick();
    rst_left = 16;
    check("pre_rst_ack",   64'(o_ack), 64'd1);
    check("pre_rst_txrst", 64'(o_tx_reset_n), 64'd0);
    #2 i_reset = 1'b0;
    #1;
    model_hard_reset();
    check("async_ack",   64'(o_ack), 64'd0);
    check("async_txrst", 64'(o_tx_reset_n), 64'd1);
    check("async_sw",    64'(o_sw), 64'd0);
    check("async_data",  64'(o_gpio_data), 64'd0);
    tick();
    i_reset = 1'b1;
    send_cmd(8'h01, 23'h000015, 3, "release");
    idle_cycles(20, "release");
    send_cmd(8'h03, 23'h000001, 0, "read_cleared");

    // Random commands against the model.
    for (int it = 0; it < 40; it++) begin
      randomize_inputs();
      sel = int'($urandom_range(0, 5));
      pl  = 23'($urandom);
      case (sel)
        0: op = 8'h01;
        1: op = 8'h02;
        2, 5: op = 8'h03;
        3: op = 8'h04;
        default: begin
          op = 8'($urandom);
          if (op >= 8'h01 && op <= 8'h04) op = 8'hA5;
        end
      endcase
      send_cmd(op, pl, int'($urandom_range(0, 2)), "rand");
      idle_cycles(int'($urandom_range(0, 3)), "rand_gap");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
